// File: rtl/fmadd_mantissa_normalizer.sv
// fmadd_mantissa_normalizer
// Takes the raw mantissa sum (plus carry-out) from the FMADD adder and
// left-normalizes it a few bits per cycle until the MSB is set or the
// exponent bottoms out at 1. The result is held with valid/ready for the
// rounding stage.
module fmadd_mantissa_normalizer #(
    parameter int std  = 31,
    parameter int man  = 22,
    parameter int exp  = 7,
    parameter int STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*man+3:0]     in_mantissa,
    input  logic                 in_carry,
    input  logic [exp+1:0]       in_exponent,
    input  logic                 in_sticky,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*man+3:0]     out_mantissa,
    output logic [exp+1:0]       out_exponent,
    output logic                 out_sticky,
    output logic                 out_zero,
    output logic                 out_underflow,
    output logic                 out_overflow
);

    localparam int W = 2 * man + 4;
    localparam int E = exp + 2;
    localparam logic [E-1:0] EXP_OVF = E'((1 << (exp + 1)) - 1);

    // std only describes the surrounding word format; it is referenced here
    // so a nonsensical parameter set is at least visible in elaboration.
    if (STEP < 1 || STEP > 8 || std < man) begin : g_param_guard
    end

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   mant;
    logic [W-1:0]   mant_next;
    logic [E-1:0]   exp_reg;
    logic [E-1:0]   exp_next;
    logic           sticky;
    logic           sticky_next;
    logic           zero;
    logic           zero_next;
    logic           underflow;
    logic           underflow_next;
    logic           overflow;
    logic           overflow_next;

    logic [STEP-1:0] probe;
    logic [E-1:0]    lead;
    logic [E-1:0]    limit;
    logic [E-1:0]    shift;
    logic [W-1:0]    norm_mant;
    logic [E-1:0]    norm_exp;
    logic [E-1:0]    inc_exp;

    assign in_ready      = (state == IDLE) & ~rst;
    assign out_valid     = (state == DONE);
    assign out_mantissa  = mant;
    assign out_exponent  = exp_reg;
    assign out_sticky    = sticky;
    assign out_zero      = zero;
    assign out_underflow = underflow;
    assign out_overflow  = overflow;
    assign inc_exp       = in_exponent + E'(1);

    // Leading-zero count over the top STEP bits, then the shift for this
    // cycle, clamped so the exponent never drops below 1.
    always_comb begin
        probe = mant[W-1 -: STEP];
        lead  = '0;
        for (int i = 0; i < STEP; i++) begin
            if (!probe[STEP-1]) begin
                lead  = lead + E'(1);
                probe = probe << 1;
            end
        end
        limit     = exp_reg - E'(1);
        shift     = (lead > limit) ? limit : lead;
        norm_mant = mant << shift;
        norm_exp  = exp_reg - shift;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers; these double as the held output values in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mant      <= '0;
            exp_reg   <= '0;
            sticky    <= 1'b0;
            zero      <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mant      <= mant_next;
            exp_reg   <= exp_next;
            sticky    <= sticky_next;
            zero      <= zero_next;
            underflow <= underflow_next;
            overflow  <= overflow_next;
        end
    end

    // Next-state and datapath update: load on accept, shift in NORM,
    // hold everything in DONE until the consumer takes it.
    always_comb begin
        state_next     = state;
        mant_next      = mant;
        exp_next       = exp_reg;
        sticky_next    = sticky;
        zero_next      = zero;
        underflow_next = underflow;
        overflow_next  = overflow;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    zero_next      = 1'b0;
                    underflow_next = 1'b0;
                    overflow_next  = 1'b0;
                    if (in_carry) begin
                        mant_next     = {1'b1, in_mantissa[W-1:1]};
                        exp_next      = inc_exp;
                        sticky_next   = in_sticky | in_mantissa[0];
                        overflow_next = (inc_exp >= EXP_OVF);
                        state_next    = DONE;
                    end else if (in_mantissa == '0) begin
                        mant_next   = '0;
                        exp_next    = '0;
                        sticky_next = in_sticky;
                        zero_next   = 1'b1;
                        state_next  = DONE;
                    end else begin
                        mant_next   = in_mantissa;
                        exp_next    = in_exponent;
                        sticky_next = in_sticky;
                        state_next  = NORM;
                    end
                end
            end
            NORM: begin
                if (mant[W-1] || (exp_reg <= E'(1))) begin
                    underflow_next = ~mant[W-1];
                    overflow_next  = (exp_reg >= EXP_OVF);
                    state_next     = DONE;
                end else begin
                    mant_next = norm_mant;
                    exp_next  = norm_exp;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fmadd_mantissa_normalizer.sv
// Scoreboard bench for fmadd_mantissa_normalizer: the driver pushes the
// hand-computed result of each operand, the monitor pops and compares
// whenever a new result appears, including accept-to-valid latency.
module tb_fmadd_mantissa_normalizer;

    localparam int W = 48;
    localparam int E = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_mantissa = '0;
    logic          in_carry = 1'b0;
    logic [E-1:0]  in_exponent = '0;
    logic          in_sticky = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_mantissa;
    logic [E-1:0]  out_exponent;
    logic          out_sticky;
    logic          out_zero;
    logic          out_underflow;
    logic          out_overflow;

    typedef struct {
        string        name;
        logic         carry;
        logic [W-1:0] mant;
        logic [E-1:0] expo;
        logic         sticky;
        logic [W-1:0] e_mant;
        logic [E-1:0] e_exp;
        logic         e_sticky;
        logic         e_zero;
        logic         e_uf;
        logic         e_of;
        int           e_lat;
        int           acc_cycle;
    } vec_t;

    vec_t         sb[$];
    vec_t         cur;
    int           checks = 0;
    int           failures = 0;
    int           cycle = 0;
    bit           in_txn = 0;
    logic [60:0]  snap;

    fmadd_mantissa_normalizer #(
        .std(31), .man(22), .exp(7), .STEP(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mantissa(in_mantissa),
        .in_carry(in_carry),
        .in_exponent(in_exponent),
        .in_sticky(in_sticky),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mantissa(out_mantissa),
        .out_exponent(out_exponent),
        .out_sticky(out_sticky),
        .out_zero(out_zero),
        .out_underflow(out_underflow),
        .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string n, input logic c, input logic [W-1:0] m,
                                input logic [E-1:0] e, input logic s,
                                input logic [W-1:0] em, input logic [E-1:0] ee,
                                input logic es, input logic ez, input logic eu,
                                input logic eo, input int lat);
        vec_t v;
        v.name = n; v.carry = c; v.mant = m; v.expo = e; v.sticky = s;
        v.e_mant = em; v.e_exp = ee; v.e_sticky = es; v.e_zero = ez;
        v.e_uf = eu; v.e_of = eo; v.e_lat = lat; v.acc_cycle = 0;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input bit track);
        int waited = 0;
        @(negedge clk);
        in_carry    = v.carry;
        in_mantissa = v.mant;
        in_exponent = v.expo;
        in_sticky   = v.sticky;
        in_valid    = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput({v.name, "_accept_timeout"}, 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        v.acc_cycle = cycle;
        if (track) sb.push_back(v);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((sb.size() != 0 || out_valid) && n < 100);
        if (sb.size() != 0 || out_valid) checkOutput({name, "_done_timeout"}, 64'd1, 64'd0);
    endtask

    // Monitor: compare each new result against the scoreboard head, then
    // verify the outputs stay frozen while the result is being held.
    always @(negedge clk) begin
        if (rst || !out_valid) begin
            in_txn = 0;
        end else if (!in_txn) begin
            in_txn = 1;
            snap = {out_mantissa, out_exponent, out_sticky, out_zero, out_underflow, out_overflow};
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 64'd1, 64'd0);
            end else begin
                cur = sb.pop_front();
                checkOutput({cur.name, "_mant"}, 64'(out_mantissa), 64'(cur.e_mant));
                checkOutput({cur.name, "_exp"}, 64'(out_exponent), 64'(cur.e_exp));
                checkOutput({cur.name, "_sticky"}, 64'(out_sticky), 64'(cur.e_sticky));
                checkOutput({cur.name, "_zero"}, 64'(out_zero), 64'(cur.e_zero));
                checkOutput({cur.name, "_underflow"}, 64'(out_underflow), 64'(cur.e_uf));
                checkOutput({cur.name, "_overflow"}, 64'(out_overflow), 64'(cur.e_of));
                checkOutput({cur.name, "_latency"}, 64'(cycle - cur.acc_cycle + 1), 64'(cur.e_lat));
            end
        end else begin
            checkOutput("hold_stable",
                        64'({out_mantissa, out_exponent, out_sticky, out_zero, out_underflow, out_overflow}),
                        64'(snap));
        end
    end

    initial begin
        vec_t c1, c2, c3, c4, c5, cx;
        int saw;

        c1 = mk("case1_carry", 1'b1, 48'h800000000001, 9'd100, 1'b0,
                48'hC00000000000, 9'd101, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        c2 = mk("case2_carry_ovf", 1'b1, 48'h000000000000, 9'd254, 1'b0,
                48'h800000000000, 9'd255, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        c3 = mk("case3_k47", 1'b0, 48'h000000000001, 9'd200, 1'b0,
                48'h800000000000, 9'd153, 1'b0, 1'b0, 1'b0, 1'b0, 14);
        c4 = mk("case4_clamp", 1'b0, 48'h001000000000, 9'd5, 1'b0,
                48'h010000000000, 9'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        c5 = mk("case5_zero", 1'b0, 48'h000000000000, 9'd77, 1'b1,
                48'h000000000000, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1);

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_mant", 64'(out_mantissa), 64'd0);
        checkOutput("rst_exp", 64'(out_exponent), 64'd0);
        checkOutput("rst_flags", 64'({out_sticky, out_zero, out_underflow, out_overflow}), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        applyStimulus(c1, 1'b1); waitIdle("case1");
        applyStimulus(c2, 1'b1); waitIdle("case2");
        applyStimulus(c3, 1'b1); waitIdle("case3");
        applyStimulus(c4, 1'b1); waitIdle("case4");

        // Five leading zeros: shift 4 then 1
        cx = mk("k5", 1'b0, 48'h040000000000, 9'd20, 1'b1,
                48'h800000000000, 9'd15, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(cx, 1'b1); waitIdle("k5");
        // Exponent already at 1 with MSB clear: immediate underflow
        cx = mk("exp1_uf", 1'b0, 48'h400000000000, 9'd1, 1'b0,
                48'h400000000000, 9'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        applyStimulus(cx, 1'b1); waitIdle("exp1_uf");
        // Already normalized, large exponent: overflow via NORM path
        cx = mk("norm_ovf", 1'b0, 48'h800000000000, 9'd300, 1'b0,
                48'h800000000000, 9'd300, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        applyStimulus(cx, 1'b1); waitIdle("norm_ovf");
        // Four leading zeros exactly one step
        cx = mk("k4", 1'b0, 48'h0F0000000000, 9'd10, 1'b0,
                48'hF00000000000, 9'd6, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(cx, 1'b1); waitIdle("k4");

        // Zero result held under backpressure, in_valid pulses ignored
        out_ready = 1'b0;
        applyStimulus(c5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
            in_valid    = (i % 2 == 0);
            in_carry    = 1'b1;
            in_mantissa = 48'h000000000123;
            in_exponent = 9'd9;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("release_in_ready_same", 64'(in_ready), 64'd0);
        @(negedge clk);
        checkOutput("release_in_ready_next", 64'(in_ready), 64'd1);
        checkOutput("release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("case5_consumed", 64'(sb.size()), 64'd0);

        // Reset in the middle of normalization discards the operand
        applyStimulus(c3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready_after", 64'(in_ready), 64'd1);
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) saw++;
        end
        checkOutput("midrst_no_output", 64'(saw), 64'd0);
        cx = c1;
        cx.name = "case6_after_rst";
        applyStimulus(cx, 1'b1); waitIdle("case6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
